// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity encodings and framing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: prescale down-counter emitting one tick per reload.
module uart_baud_tick #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic [W-1:0] prescale,
    output logic         tick
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= prescale;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // A restart swallows the tick so the first frame tick lands a full period after the edge.
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sync, start detect, 3-sample majority vote, framing and output register.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  rx_in,
    input  logic                  out_ready,
    output logic [7:0]            p_data,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stop_error,
    output logic                  overrun,
    output logic                  busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [SC_W-1:0] SC_V0   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_V1   = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] SC_V2   = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    state_t                 state, state_n;
    logic                   sync_q, rxs, rxs_d;
    logic                   tick;
    logic [SC_W-1:0]        sc;
    logic [BC_W-1:0]        bit_cnt;
    logic                   v0, v1, vote;
    logic [DATA_BITS-1:0]   shift;
    logic                   par_bit, par_en_q, par_typ_q, par_err_c;
    logic                   fall, at_v2, at_wrap;
    logic                   start_det, complete;

    uart_baud_tick #(.W(PRESCALE_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart  (start_det),
        .prescale (prescale),
        .tick     (tick)
    );

    assign fall      = rxs_d & ~rxs;
    assign at_v2     = tick && (sc == SC_V2);
    assign at_wrap   = tick && (sc == SC_LAST);
    assign vote      = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
    assign par_err_c = par_en_q & (^shift ^ par_bit ^ (par_typ_q == PAR_ODD));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        complete  = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (fall) begin
                    state_n   = START;
                    start_det = 1'b1;
                end
                START: begin
                    if (at_v2 && vote) state_n = IDLE;
                    else if (at_wrap)  state_n = DATA;
                end
                DATA: if (at_wrap && bit_cnt == BC_LAST) state_n = par_en_q ? PARITY : STOP;
                PARITY: if (at_wrap) state_n = STOP;
                STOP: if (at_v2) begin
                    state_n  = IDLE;
                    complete = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            sc         <= '0;
            bit_cnt    <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            shift      <= '0;
            par_bit    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_error  <= 1'b0;
            stop_error <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync_q <= rx_in;
            rxs    <= sync_q;
            rxs_d  <= rxs;

            if (start_det) begin
                sc        <= '0;
                bit_cnt   <= '0;
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
            end else if (tick && state != IDLE) begin
                sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
                if (sc == SC_V0) v0 <= rxs;
                if (sc == SC_V1) v1 <= rxs;
            end

            if (state == DATA && at_v2)   shift[bit_cnt] <= vote;
            if (state == DATA && at_wrap) bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && at_v2) par_bit <= vote;

            // A completing frame outranks a same-cycle handshake.
            if (complete) begin
                p_data     <= shift;
                par_error  <= par_err_c;
                stop_error <= ~vote;
                overrun    <= data_valid & ~out_ready;
                data_valid <= 1'b1;
            end else if (data_valid && out_ready) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule
